// File: rtl/dmem_responder_pkg.sv
// Shared widths, memory op encodings and FSM state type for the data-memory responder.
package dmem_responder_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: load extract/extend, store merge and access fault check.
module dmem_lane_align
  import dmem_responder_pkg::*;
#(
  parameter int unsigned IDX_W = 10
) (
  input  logic                  write,
  input  logic [2:0]            op,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] old_word,
  output logic [DATA_WIDTH-1:0] rdata_c,
  output logic [DATA_WIDTH-1:0] new_word_c,
  output logic                  err_c
);

  function automatic logic [DATA_WIDTH-1:0] load_extract(input logic [DATA_WIDTH-1:0] word,
                                                          input logic [1:0] lane,
                                                          input logic [2:0] lop);
    logic [DATA_WIDTH-1:0] sh;
    sh = word >> {lane, 3'b000};
    case (lop)
      MEM_B:   return {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
      MEM_H:   return {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
      MEM_BU:  return {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
      MEM_HU:  return {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
      MEM_W:   return word;
      default: return '0;
    endcase
  endfunction

  // Only the addressed lane bits are replaced; faulting ops never reach the array.
  function automatic logic [DATA_WIDTH-1:0] store_merge(input logic [DATA_WIDTH-1:0] old,
                                                         input logic [DATA_WIDTH-1:0] data,
                                                         input logic [1:0] lane,
                                                         input logic [2:0] sop);
    logic [DATA_WIDTH-1:0] mask;
    logic [4:0]            s;
    s = {lane, 3'b000};
    case (sop)
      MEM_B:   mask = DATA_WIDTH'(8'hFF) << s;
      MEM_H:   mask = DATA_WIDTH'(16'hFFFF) << s;
      default: mask = '1;
    endcase
    return (old & ~mask) | ((data << s) & mask);
  endfunction

  logic misalign, bad_op, out_of_range;

  always_comb begin
    misalign = 1'b0;
    bad_op   = 1'b0;
    case (op)
      MEM_H, MEM_HU: misalign = addr[0];
      MEM_W:         misalign = |addr[1:0];
      default:       misalign = 1'b0;
    endcase
    if (write) bad_op = (op > MEM_W);
    else       bad_op = (op == 3'b011) || (op == 3'b110) || (op == 3'b111);
    out_of_range = |(addr >> (IDX_W + 2));
    err_c = misalign | bad_op | out_of_range;
  end

  assign rdata_c    = (err_c || write) ? '0 : load_extract(old_word, addr[1:0], op);
  assign new_word_c = store_merge(old_word, wdata, addr[1:0], op);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with fixed access latency and fault reporting.
// Define DMEM_BACK_TO_BACK_EN to accept a new request on the same edge a response retires.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;

  dmem_state_t           state;
  logic [CNT_W-1:0]      count;
  logic                  write_q;
  logic [2:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] old_word, rdata_c, new_word_c;
  logic                  err_c, last_c, accept_c;

  assign idx      = addr_q[IDX_W+1:2];
  assign old_word = mem[idx];
  assign last_c   = (state == WAIT) && (count == '0);

  // req_ready is a pure decode of registered state (plus rsp_ready when overlapping).
`ifdef DMEM_BACK_TO_BACK_EN
  assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
`else
  assign req_ready = (state == IDLE);
`endif
  assign accept_c = req_valid && req_ready;

  dmem_lane_align #(.IDX_W(IDX_W)) u_align (
    .write      (write_q),
    .op         (op_q),
    .addr       (addr_q),
    .wdata      (wdata_q),
    .old_word   (old_word),
    .rdata_c    (rdata_c),
    .new_word_c (new_word_c),
    .err_c      (err_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      write_q   <= 1'b0;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        IDLE: ;
        WAIT: begin
          if (count != '0) begin
            count <= count - CNT_W'(1);
          end else begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata_c;
            rsp_err   <= err_c;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Placed after the case so an overlapped accept overrides the RESP->IDLE move.
      if (accept_c) begin
        write_q <= req_write;
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        count   <= CNT_W'(LATENCY - 1);
        state   <= WAIT;
      end
    end
  end

  // Array is not reset; a store commits only on its final WAIT edge.
  always_ff @(posedge clk) begin
    if (last_c && write_q && !err_c) mem[idx] <= new_word_c;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: loads/stores, faults, backpressure, reset, throughput.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int unsigned LAT = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  logic                  req_write = 1'b0;
  logic [2:0]            req_op = '0;
  logic [ADDR_WIDTH-1:0] req_addr = '0;
  logic [DATA_WIDTH-1:0] req_wdata = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transaction: push expectation on accept, pop and compare when the response appears.
  task automatic txn(input string tag, input logic wr, input logic [2:0] op,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input int bp);
    int   waitc;
    int   lat;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = (bp == 0);
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      check({tag, " accept_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    sb.push_back('{exp_rdata, exp_err});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_op    = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!rsp_valid) begin
      check({tag, " rsp_timeout"}, 32'(rsp_valid), 32'd1);
      void'(sb.pop_front());
      return;
    end
    check({tag, " latency"}, 32'(lat), 32'(LAT));
    e = sb.pop_front();
    check({tag, " rdata"}, rsp_rdata, e.rdata);
    check({tag, " err"}, 32'(rsp_err), 32'(e.err));
    for (int k = 0; k < bp; k++) begin
      @(posedge clk);
      #1;
      check({tag, " bp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " bp_rdata"}, rsp_rdata, e.rdata);
      check({tag, " bp_err"}, 32'(rsp_err), 32'(e.err));
      check({tag, " bp_req_ready"}, 32'(req_ready), 32'd0);
    end
    if (bp > 0) begin
      @(negedge clk);
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, " retire"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
  endtask

  initial begin
    int   nrsp;
    int   cyc;
    int   last;
    int   gap_exp;
    int   waitc;
    exp_t e;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    txn("sw_10", 1'b1, MEM_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    txn("lw_10", 1'b0, MEM_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    txn("sb_11", 1'b1, MEM_B, 32'h11, 32'h55, 32'h0, 1'b0, 0);
    txn("lb_11", 1'b0, MEM_B, 32'h11, 32'h0, 32'h00000055, 1'b0, 0);
    txn("lw_10b", 1'b0, MEM_W, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 0);
    txn("lh_12", 1'b0, MEM_H, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 0);
    txn("lhu_12", 1'b0, MEM_HU, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, 0);

    txn("lw_mis", 1'b0, MEM_W, 32'h11, 32'h0, 32'h0, 1'b1, 0);
    txn("sh_mis", 1'b1, MEM_H, 32'h13, 32'hFFFF, 32'h0, 1'b1, 0);
    txn("lw_after_sh", 1'b0, MEM_W, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 0);
    txn("ld_op3", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 0);
    txn("st_op4", 1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1, 0);
    txn("lw_oor", 1'b0, MEM_W, 32'h1000, 32'h0, 32'h0, 1'b1, 0);
    txn("sw_oor", 1'b1, MEM_W, 32'h1010, 32'h0, 32'h0, 1'b1, 0);
    txn("lw_after_oor", 1'b0, MEM_W, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 0);

    txn("sb_13", 1'b1, MEM_B, 32'h13, 32'h80, 32'h0, 1'b0, 0);
    txn("lb_13", 1'b0, MEM_B, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 0);
    txn("lbu_13", 1'b0, MEM_BU, 32'h13, 32'h0, 32'h00000080, 1'b0, 0);

    txn("lw_bp", 1'b0, MEM_W, 32'h10, 32'h0, 32'h80AD55EF, 1'b0, 5);

    // Reset in WAIT must abort an uncommitted store.
    txn("sw_20", 1'b1, MEM_W, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_op    = MEM_W;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("mid_wait req_ready", 32'(req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    txn("lw_20", 1'b0, MEM_W, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 0);

    // Reset while a response is held must clear it immediately.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_op    = MEM_W;
    req_addr  = 32'h20;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    waitc = 0;
    while (!rsp_valid && waitc < 20) begin
      @(posedge clk);
      #1;
      waitc++;
    end
    check("resp_hold valid", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_resp");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;

    // Continuous load stream: spacing between responses shows the throughput mode.
`ifdef DMEM_BACK_TO_BACK_EN
    gap_exp = LAT + 1;
`else
    gap_exp = LAT + 2;
`endif
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_op    = MEM_W;
    req_addr  = 32'h10;
    rsp_ready = 1'b1;
    nrsp = 0;
    cyc  = 0;
    last = -1;
    while (nrsp < 4 && cyc < 60) begin
      if (req_ready && req_valid) sb.push_back('{32'h80AD55EF, 1'b0});
      @(posedge clk);
      #1;
      cyc++;
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("stream unexpected_rsp", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("stream rdata", rsp_rdata, e.rdata);
          check("stream err", 32'(rsp_err), 32'(e.err));
        end
        if (last >= 0) check("stream gap", 32'(cyc - last), 32'(gap_exp));
        last = cyc;
        nrsp++;
      end
      if (nrsp >= 4) req_valid = 1'b0;
      else @(negedge clk);
    end
    req_valid = 1'b0;
    check("stream count", 32'(nrsp), 32'd4);
    @(posedge clk);
    #1;
    check("stream drained", 32'(rsp_valid), 32'd0);
    check("stream sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
